// File: rtl/shift_arb_pkg.sv
// Shared encodings and widths for the shift arbiter and its barrel shifter.
package shift_arb_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned ID_W    = 1;

  typedef enum logic {
    OP_SLL = 1'b0,
    OP_SRA = 1'b1
  } shift_op_e;

endpackage

// File: rtl/shift_core_32.sv
// Combinational 32-bit log shifter: 16/8/4/2/1 stages steered by shamt bits.
// Arithmetic right shift is built only when SHIFT_ARB_SRA_EN is defined.
module shift_core_32
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               op_i,
  output logic [DATA_W-1:0]  result_o
);

  logic [DATA_W-1:0] s16, s8, s4, s2, s1;

`ifdef SHIFT_ARB_SRA_EN
  logic is_sra;
  logic fill;

  assign is_sra = (op_i == OP_SRA);
  assign fill   = is_sra & data_i[DATA_W-1];

  function automatic logic [DATA_W-1:0] stage(input logic [DATA_W-1:0] x,
                                              input int unsigned      amt,
                                              input logic             right,
                                              input logic             fill_bit);
    logic [DATA_W-1:0] mask;
    mask = ~({DATA_W{1'b1}} >> amt);
    if (right) return (x >> amt) | (fill_bit ? mask : '0);
    return x << amt;
  endfunction

  assign s16 = shamt_i[4] ? stage(data_i, 16, is_sra, fill) : data_i;
  assign s8  = shamt_i[3] ? stage(s16,     8, is_sra, fill) : s16;
  assign s4  = shamt_i[2] ? stage(s8,      4, is_sra, fill) : s8;
  assign s2  = shamt_i[1] ? stage(s4,      2, is_sra, fill) : s4;
  assign s1  = shamt_i[0] ? stage(s2,      1, is_sra, fill) : s2;
`else
  // Without arithmetic shift support the op select has no effect.
  logic unused_op;
  assign unused_op = op_i;

  function automatic logic [DATA_W-1:0] stage(input logic [DATA_W-1:0] x,
                                              input int unsigned      amt);
    return x << amt;
  endfunction

  assign s16 = shamt_i[4] ? stage(data_i, 16) : data_i;
  assign s8  = shamt_i[3] ? stage(s16,     8) : s16;
  assign s4  = shamt_i[2] ? stage(s8,      4) : s8;
  assign s2  = shamt_i[1] ? stage(s4,      2) : s4;
  assign s1  = shamt_i[0] ? stage(s2,      1) : s2;
`endif

  assign result_o = s1;

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of a shared barrel shifter, with one
// registered result stage under valid/ready. SRA support: SHIFT_ARB_SRA_EN.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_op,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic [DATA_W-1:0]  resp_data
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [ID_W-1:0]    id_q;
  logic [DATA_W-1:0]  data_q;
  logic [ID_W-1:0]    last_grant_q;

  logic               can_accept;
  logic               gnt0, gnt1;
  logic               xfer;
  logic [ID_W-1:0]    gnt_id;
  logic [DATA_W-1:0]  sel_data;
  logic [SHAMT_W-1:0] sel_shamt;
  logic               sel_op;
  logic [DATA_W-1:0]  shift_res;

  assign can_accept = (state_q == ST_EMPTY) || resp_ready;

  // Port 0 wins when alone, or in a conflict when fixed priority is set or
  // port 1 took the previous grant.
  assign gnt0 = req0_valid &&
                (!req1_valid || FIXED_PRIO || (last_grant_q == ID_W'(1)));
  assign gnt1 = req1_valid && !gnt0;

  // Reset gates ready so nothing is accepted while the block is held in reset.
  assign req0_ready = gnt0 && can_accept && reset_n;
  assign req1_ready = gnt1 && can_accept && reset_n;
  assign xfer       = req0_ready || req1_ready;
  assign gnt_id     = ID_W'(gnt1);

  assign sel_data  = gnt1 ? req1_data  : req0_data;
  assign sel_shamt = gnt1 ? req1_shamt : req0_shamt;
  assign sel_op    = gnt1 ? req1_op    : req0_op;

  shift_core_32 u_core (
    .data_i   (sel_data),
    .shamt_i  (sel_shamt),
    .op_i     (sel_op),
    .result_o (shift_res)
  );

  always_comb begin
    // NOTE: default assignment first so every path drives state_d; no latch.
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (resp_ready && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      id_q         <= '0;
      data_q       <= '0;
      last_grant_q <= ID_W'(1);
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q <= state_d;
      if (xfer) begin
        data_q       <= shift_res;
        id_q         <= gnt_id;
        last_grant_q <= gnt_id;
      end
    end
  end

  assign resp_valid = (state_q == ST_FULL);
  assign resp_id    = id_q;
  assign resp_data  = data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter (round-robin and fixed-priority).
module tb_shift_arbiter;

  logic        clock;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        req0_op, req1_op;
  logic        resp_valid, resp_ready;
  logic [0:0]  resp_id;
  logic [31:0] resp_data;

  logic        fp_v0, fp_v1, fp_r0, fp_r1, fp_resp_valid;
  logic [0:0]  fp_resp_id;
  logic [31:0] fp_resp_data;

  int checks   = 0;
  int failures = 0;

  shift_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data)
  );

  shift_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(fp_v0), .req0_ready(fp_r0), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(fp_v1), .req1_ready(fp_r1), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .resp_valid(fp_resp_valid), .resp_ready(resp_ready),
    .resp_id(fp_resp_id), .resp_data(fp_resp_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [31:0] d, input logic [4:0] s, input logic op);
    req0_valid = v; req0_data = d; req0_shamt = s; req0_op = op;
  endtask

  task automatic drive1(input logic v, input logic [31:0] d, input logic [4:0] s, input logic op);
    req1_valid = v; req1_data = d; req1_shamt = s; req1_op = op;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] sra_exp;

  initial begin
`ifdef SHIFT_ARB_SRA_EN
    sra_exp = 32'hFFFF_FFFF;
`else
    sra_exp = 32'h0000_0000;
`endif
    reset_n = 1'b0;
    resp_ready = 1'b0;
    fp_v0 = 1'b0; fp_v1 = 1'b0;
    drive0(1'b1, 32'h1, 5'd4, 1'b0);
    drive1(1'b1, 32'h1, 5'd4, 1'b0);

    // Reset state, and ready held low while in reset even with valid requests.
    #2;
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_id",    32'(resp_id),    32'd0);
    check("rst_data",  resp_data,       32'd0);
    check("rst_rdy0",  32'(req0_ready), 32'd0);
    check("rst_rdy1",  32'(req1_ready), 32'd0);
    step();
    reset_n = 1'b1;
    drive1(1'b0, 32'h0, 5'd0, 1'b0);
    resp_ready = 1'b1;

    // Single sll request on port 0.
    #3;
    check("single_rdy0", 32'(req0_ready), 32'd1);
    check("single_rdy1", 32'(req1_ready), 32'd0);
    step();
    drive0(1'b0, 32'h0, 5'd0, 1'b0);
    check("single_valid", 32'(resp_valid), 32'd1);
    check("single_id",    32'(resp_id),    32'd0);
    check("single_data",  resp_data,       32'h0000_0010);
    step();
    check("drain_valid", 32'(resp_valid), 32'd0);

    // shamt 31 on a negative operand from port 1.
    drive1(1'b1, 32'h8000_0000, 5'd31, 1'b1);
    #3;
    check("sra_rdy1", 32'(req1_ready), 32'd1);
    step();
    drive1(1'b0, 32'h0, 5'd0, 1'b0);
    check("sra_id",   32'(resp_id), 32'd1);
    check("sra_data", resp_data,    sra_exp);
    step();

    // Continuous conflict: grants alternate 0,1,0,1.
    drive0(1'b1, 32'h0000_0003, 5'd1, 1'b0);
    drive1(1'b1, 32'h0000_0005, 5'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #3;
      check($sformatf("rr_rdy0_%0d", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_rdy1_%0d", i), 32'(req1_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check($sformatf("rr_id_%0d", i),   32'(resp_id), (i % 2 == 0) ? 32'd0 : 32'd1);
      check($sformatf("rr_data_%0d", i), resp_data, (i % 2 == 0) ? 32'h6 : 32'h14);
    end
    drive0(1'b0, 32'h0, 5'd0, 1'b0);
    drive1(1'b0, 32'h0, 5'd0, 1'b0);
    step();

    // Backpressure: hold result, pending port 1 request waits then goes through.
    resp_ready = 1'b0;
    drive0(1'b1, 32'h0000_00FF, 5'd8, 1'b0);
    step();
    drive0(1'b0, 32'h0, 5'd0, 1'b0);
    drive1(1'b1, 32'h0000_0001, 5'd31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("bp_rdy0_%0d", i),  32'(req0_ready), 32'd0);
      check($sformatf("bp_rdy1_%0d", i),  32'(req1_ready), 32'd0);
      check($sformatf("bp_valid_%0d", i), 32'(resp_valid), 32'd1);
      check($sformatf("bp_data_%0d", i),  resp_data,       32'h0000_FF00);
      step();
    end
    resp_ready = 1'b1;
    #3;
    check("bp_release_rdy1", 32'(req1_ready), 32'd1);
    step();
    drive1(1'b0, 32'h0, 5'd0, 1'b0);
    check("bp_next_valid", 32'(resp_valid), 32'd1);
    check("bp_next_id",    32'(resp_id),    32'd1);
    check("bp_next_data",  resp_data,       32'h8000_0000);
    step();
    check("bp_empty", 32'(resp_valid), 32'd0);

    // Fixed-priority instance: port 0 wins every conflict.
    fp_v0 = 1'b1; fp_v1 = 1'b1;
    drive0(1'b0, 32'h0000_0003, 5'd1, 1'b0);
    drive1(1'b0, 32'h0000_0005, 5'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("fp_rdy0_%0d", i), 32'(fp_r0), 32'd1);
      check($sformatf("fp_rdy1_%0d", i), 32'(fp_r1), 32'd0);
      step();
      check($sformatf("fp_id_%0d", i), 32'(fp_resp_id), 32'd0);
    end
    fp_v0 = 1'b0; fp_v1 = 1'b0;
    step();

    // Reset mid-operation with a held result; shamt 0 leaves data unchanged.
    resp_ready = 1'b0;
    drive1(1'b1, 32'h1234_5678, 5'd0, 1'b0);
    step();
    drive1(1'b0, 32'h0, 5'd0, 1'b0);
    check("hold_data", resp_data, 32'h1234_5678);
    check("hold_id",   32'(resp_id), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", 32'(resp_valid), 32'd0);
    check("async_id",    32'(resp_id),    32'd0);
    check("async_data",  resp_data,       32'd0);
    drive0(1'b1, 32'h0000_0001, 5'd0, 1'b0);
    drive1(1'b1, 32'h0000_0002, 5'd0, 1'b0);
    resp_ready = 1'b1;
    #1;
    check("inrst_rdy0", 32'(req0_ready), 32'd0);
    step();
    reset_n = 1'b1;
    #3;
    check("post_rst_rdy0", 32'(req0_ready), 32'd1);
    check("post_rst_rdy1", 32'(req1_ready), 32'd0);
    step();
    check("post_rst_id",   32'(resp_id), 32'd0);
    check("post_rst_data", resp_data,    32'h0000_0001);
    drive0(1'b0, 32'h0, 5'd0, 1'b0);
    drive1(1'b0, 32'h0, 5'd0, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
